// File: rtl/prbs_stream_gen_pkg.sv
// Shared definitions for the PRBS/counter stream generator: LFSR taps,
// pattern selection encoding and the 32-step PRBS31 advance function.
package prbs_stream_gen_pkg;

    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

    typedef enum logic {
        PAT_PRBS31 = 1'b0,
        PAT_COUNT  = 1'b1
    } pattern_e;

    // Runs 32 serial PRBS31 steps; the first feedback bit lands in word bit 31.
    // Result is {next_state[30:0], word[31:0]}.
    function automatic logic [62:0] prbs31_advance32(input logic [30:0] state);
        logic [30:0] s;
        logic [31:0] w;
        logic        b;
        s = state;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            b         = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
            w[31 - k] = b;
            s         = {s[29:0], b};
        end
        return {s, w};
    endfunction

endpackage

// File: rtl/prbs_stream_gen_lane.sv
// One 32-bit PRBS31 lane: presents the word of the current state and moves
// to the next state only when the top level loads a beat from it.
module prbs31_lane
    import prbs_stream_gen_pkg::*;
#(
    parameter logic [30:0] SEED = 31'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    output logic [31:0] o_word
);

    logic [30:0] r_state;
    logic [62:0] w_next;

    assign w_next = prbs31_advance32(r_state);
    assign o_word = w_next[31:0];

    // LFSR state register; reseeds on reset, advances one beat per load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= w_next[62:32];
        end
    end

endmodule

// File: rtl/prbs_stream_gen.sv
// Pattern source broadcasting each beat on a golden and a test AXI-Stream
// master, with optional single-bit error injection on the test copy.
module prbs_stream_gen
    import prbs_stream_gen_pkg::*;
#(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [30:0] SEED        = 31'h0000_0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pattern_sel,
    input  logic                   inject_error,
    input  logic [15:0]            inject_lane,
    output logic [TDATA_WIDTH-1:0] M_AXIS_0_TDATA,
    output logic                   M_AXIS_0_TVALID,
    input  logic                   M_AXIS_0_TREADY,
    output logic [TDATA_WIDTH-1:0] M_AXIS_1_TDATA,
    output logic                   M_AXIS_1_TVALID,
    input  logic                   M_AXIS_1_TREADY,
    output logic [31:0]            word_count,
    output logic [31:0]            inject_count,
    output logic                   inject_pending
);

    localparam int          NLINKS   = TDATA_WIDTH / 32;
    localparam logic [16:0] NLINKS_W = 17'(NLINKS);

    logic [TDATA_WIDTH-1:0] r_data0;
    logic [TDATA_WIDTH-1:0] r_data1;
    logic                   r_valid0;
    logic                   r_valid1;
    logic [31:0]            r_beatCnt;
    logic [31:0]            r_wordCount;
    logic [31:0]            r_injCount;
    logic                   r_pending;

    logic                   w_held;
    logic                   w_done;
    logic                   w_load;
    logic                   w_isCount;
    logic                   w_injNow;
    logic [15:0]            w_injLane;
    logic [TDATA_WIDTH-1:0] w_prbsWord;
    logic [TDATA_WIDTH-1:0] w_cntWord;
    logic [TDATA_WIDTH-1:0] w_beat;
    logic [TDATA_WIDTH-1:0] w_mask;

    assign w_held    = r_valid0 | r_valid1;
    assign w_done    = w_held & (~r_valid0 | M_AXIS_0_TREADY) & (~r_valid1 | M_AXIS_1_TREADY);
    assign w_load    = enable & (~w_held | w_done);
    assign w_isCount = (pattern_e'(pattern_sel) == PAT_COUNT);
    assign w_injNow  = r_pending | inject_error;
    assign w_injLane = ({1'b0, inject_lane} < NLINKS_W) ? inject_lane : 16'd0;
    assign w_beat    = w_isCount ? w_cntWord : w_prbsWord;

    for (genvar i = 0; i < NLINKS; i++) begin : g_lane
        prbs31_lane #(
            .SEED (31'(SEED + 31'(i)))
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load & ~w_isCount),
            .o_word (w_prbsWord[i*32 +: 32])
        );

        assign w_cntWord[i*32 +: 32] = 32'(r_beatCnt * 32'(NLINKS) + 32'(i));
        assign w_mask[i*32 +: 32]    = {31'b0, w_injNow & (w_injLane == 16'(i))};
    end

    // Beat register and per-master valid flags; a load refills both copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data0  <= '0;
            r_data1  <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else if (w_load) begin
            r_data0  <= w_beat ^ w_mask;
            r_data1  <= w_beat;
            r_valid0 <= 1'b1;
            r_valid1 <= 1'b1;
        end else begin
            if (M_AXIS_0_TREADY) r_valid0 <= 1'b0;
            if (M_AXIS_1_TREADY) r_valid1 <= 1'b0;
        end
    end

    // Counting-pattern beat index and completed-beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beatCnt   <= '0;
            r_wordCount <= '0;
        end else begin
            if (w_load && w_isCount) r_beatCnt <= r_beatCnt + 32'd1;
            if (w_done) r_wordCount <= r_wordCount + 32'd1;
        end
    end

    // Error request latch; a request is consumed by the next loaded beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_injCount <= '0;
        end else if (w_load) begin
            r_pending <= 1'b0;
            if (w_injNow) r_injCount <= r_injCount + 32'd1;
        end else if (inject_error) begin
            r_pending <= 1'b1;
        end
    end

    assign M_AXIS_0_TDATA  = r_data0;
    assign M_AXIS_0_TVALID = r_valid0;
    assign M_AXIS_1_TDATA  = r_data1;
    assign M_AXIS_1_TVALID = r_valid1;
    assign word_count      = r_wordCount;
    assign inject_count    = r_injCount;
    assign inject_pending  = r_pending;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Scoreboard bench for prbs_stream_gen: a 32-bit and a 64-bit instance share
// stimulus; a behavioural model queues expected beats per master.
module tb_prbs_stream_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        patternSel = 1'b0;
    logic        injectError = 1'b0;
    logic [15:0] injectLane = 16'd0;
    logic        rdy0 = 1'b0;
    logic        rdy1 = 1'b0;

    logic [63:0] tdata0w, tdata1w;
    logic        tvalid0w, tvalid1w;
    logic [31:0] wcW, icW;
    logic        pendW;

    logic [31:0] tdata0n, tdata1n;
    logic        tvalid0n, tvalid1n;
    logic [31:0] wcN, icN;
    logic        pendN;

    int totalChecks = 0;
    int badChecks = 0;

    typedef struct {
        logic [63:0] d;
        logic [31:0] e;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    logic [30:0] mLfsr0, mLfsr1;
    logic [31:0] mCnt, mWc, mIc;
    logic        mv0, mv1, mPend;

    prbs_stream_gen #(.TDATA_WIDTH(64), .SEED(31'h1)) dutWide (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(patternSel),
        .inject_error(injectError), .inject_lane(injectLane),
        .M_AXIS_0_TDATA(tdata0w), .M_AXIS_0_TVALID(tvalid0w), .M_AXIS_0_TREADY(rdy0),
        .M_AXIS_1_TDATA(tdata1w), .M_AXIS_1_TVALID(tvalid1w), .M_AXIS_1_TREADY(rdy1),
        .word_count(wcW), .inject_count(icW), .inject_pending(pendW)
    );

    prbs_stream_gen #(.TDATA_WIDTH(32), .SEED(31'h1)) dutNarrow (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(patternSel),
        .inject_error(injectError), .inject_lane(injectLane),
        .M_AXIS_0_TDATA(tdata0n), .M_AXIS_0_TVALID(tvalid0n), .M_AXIS_0_TREADY(rdy0),
        .M_AXIS_1_TDATA(tdata1n), .M_AXIS_1_TVALID(tvalid1n), .M_AXIS_1_TREADY(rdy1),
        .word_count(wcN), .inject_count(icN), .inject_pending(pendN)
    );

    // Free-running 100 MHz stream clock.
    always #5 clk = ~clk;

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference PRBS31: shift the feedback bit into the word from the right.
    task automatic prbsWord(input logic [30:0] si, output logic [30:0] so, output logic [31:0] w);
        logic [30:0] s;
        logic        fb;
        s = si;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            fb = s[30] ^ s[27];
            w  = {w[30:0], fb};
            s  = {s[29:0], fb};
        end
        so = s;
    endtask

    task automatic modelReset();
        mLfsr0 = 31'd1;
        mLfsr1 = 31'd2;
        mCnt   = '0;
        mWc    = '0;
        mIc    = '0;
        mv0    = 1'b0;
        mv1    = 1'b0;
        mPend  = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_d0w"}, tdata0w, 64'd0);
        checkOutput({tag, "_d1w"}, tdata1w, 64'd0);
        checkOutput({tag, "_d0n"}, 64'(tdata0n), 64'd0);
        checkOutput({tag, "_d1n"}, 64'(tdata1n), 64'd0);
        checkOutput({tag, "_vld"}, 64'({tvalid0w, tvalid1w, tvalid0n, tvalid1n}), 64'd0);
        checkOutput({tag, "_cnt"}, {wcW, icW}, 64'd0);
        checkOutput({tag, "_cntn"}, {wcN, icN}, 64'd0);
        checkOutput({tag, "_pend"}, 64'({pendW, pendN}), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        injectError = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkReset("reset");
    endtask

    // One clock of stimulus: compare DUT state with the model, pop accepted
    // beats, then advance the model across the coming edge.
    task automatic applyStimulus(input logic en, input logic ps, input logic inj,
                                 input logic [15:0] lane, input logic r0, input logic r1);
        logic        held, done, load, injNow;
        logic [31:0] w0, w1, e;
        logic [30:0] ns;
        beat_t       b;
        @(negedge clk);
        enable = en;
        patternSel = ps;
        injectError = inj;
        injectLane = lane;
        rdy0 = r0;
        rdy1 = r1;

        checkOutput("valid0", 64'({tvalid0w, tvalid0n}), 64'({mv0, mv0}));
        checkOutput("valid1", 64'({tvalid1w, tvalid1n}), 64'({mv1, mv1}));
        checkOutput("word_count", {wcW, wcN}, {mWc, mWc});
        checkOutput("inject_count", {icW, icN}, {mIc, mIc});
        checkOutput("inject_pending", 64'({pendW, pendN}), 64'({mPend, mPend}));

        if (mv0 && r0) begin
            if (q0.size() == 0) checkOutput("q0_underflow", 64'd1, 64'd0);
            else begin
                b = q0.pop_front();
                checkOutput("data0_wide", tdata0w, b.d);
                checkOutput("data0_narrow", 64'(tdata0n), 64'(b.e));
            end
        end
        if (mv1 && r1) begin
            if (q1.size() == 0) checkOutput("q1_underflow", 64'd1, 64'd0);
            else begin
                b = q1.pop_front();
                checkOutput("data1_wide", tdata1w, b.d);
                checkOutput("data1_narrow", 64'(tdata1n), 64'(b.e));
            end
        end

        held   = mv0 | mv1;
        done   = held && (!mv0 || r0) && (!mv1 || r1);
        load   = en && (!held || done);
        injNow = mPend | inj;
        if (done) mWc = mWc + 32'd1;

        if (load) begin
            if (ps) begin
                w0 = 32'(mCnt * 32'd2);
                w1 = 32'(mCnt * 32'd2 + 32'd1);
                e  = mCnt;
                mCnt = mCnt + 32'd1;
            end else begin
                prbsWord(mLfsr0, ns, w0);
                mLfsr0 = ns;
                prbsWord(mLfsr1, ns, w1);
                mLfsr1 = ns;
                e = w0;
            end
            b.d = {w1, w0};
            b.e = e;
            q1.push_back(b);
            if (injNow) begin
                b.d = b.d ^ ((lane == 16'd1) ? 64'h0000_0001_0000_0000 : 64'h1);
                b.e = b.e ^ 32'h1;
                mIc = mIc + 32'd1;
            end
            q0.push_back(b);
            mv0 = 1'b1;
            mv1 = 1'b1;
            mPend = 1'b0;
        end else begin
            if (r0) mv0 = 1'b0;
            if (r1) mv1 = 1'b0;
            if (inj) mPend = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        logic [63:0] held1;
        logic        rr0, rr1;
        modelReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        doReset();

        $display("[TB] PRBS31 streaming, both ready");
        applyStimulus(1, 0, 0, 0, 1, 1);
        #1;
        checkOutput("first_word_m0", 64'(tdata0n), 64'h12);
        checkOutput("first_word_m1", 64'(tdata1n), 64'h12);
        checkOutput("first_word_lane0", 64'(tdata1w[31:0]), 64'h12);
        for (int i = 0; i < 99; i++) applyStimulus(1, 0, 0, 0, 1, 1);
        #1;
        checkOutput("count_after_100", 64'(wcN), 64'd99);

        $display("[TB] counter mode, wide instance");
        doReset();
        applyStimulus(1, 1, 0, 0, 1, 1);
        #1;
        checkOutput("cnt_beat0", tdata1w, 64'h0000_0001_0000_0000);
        applyStimulus(1, 1, 0, 0, 1, 1);
        #1;
        checkOutput("cnt_beat1", tdata1w, 64'h0000_0003_0000_0002);
        applyStimulus(1, 1, 0, 0, 1, 1);
        #1;
        checkOutput("cnt_beat2", tdata0w, 64'h0000_0005_0000_0004);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1, 1);

        $display("[TB] golden master stalled");
        applyStimulus(1, 0, 0, 0, 1, 0);
        #1;
        held1 = tdata1w;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 0);
            #1;
            checkOutput("stall_data1_stable", tdata1w, held1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1, 1);

        $display("[TB] error injection");
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 1);
        #1;
        checkOutput("inject_diff_wide", tdata0w ^ tdata1w, 64'h0000_0001_0000_0000);
        checkOutput("inject_diff_narrow", 64'(tdata0n ^ tdata1n), 64'h1);
        applyStimulus(1, 1, 1, 0, 1, 1);
        applyStimulus(1, 0, 1, 16'd5, 1, 1);
        #1;
        checkOutput("inject_lane_oob", tdata0w ^ tdata1w, 64'h1);
        applyStimulus(1, 0, 0, 0, 1, 1);

        $display("[TB] mixed traffic");
        for (int i = 0; i < 60; i++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 2)), rr0, rr1);
        end

        $display("[TB] enable dropped with beat held");
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        $display("[TB] reset with beat held and error pending");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        doReset();
        applyStimulus(1, 0, 0, 0, 1, 1);
        #1;
        checkOutput("reseed_word", 64'(tdata1n), 64'h12);
        checkOutput("reseed_clean", 64'(tdata0n), 64'h12);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("q0_drained", 64'(q0.size()), 64'd0);
        checkOutput("q1_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
